// File: rtl/data_ram_responder_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package data_ram_responder_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic READY_ENABLE  = 1'b1;
    localparam logic READY_DISABLE = 1'b0;

    localparam logic [DATA_WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_DONE = 2'd2
    } rsp_state_e;

    // Any address bit above the stored word range marks the access as out of range.
    function automatic logic addr_out_of_range(input logic [ADDR_WIDTH-1:0] addr,
                                               input int depth_log2);
        return (addr >> (depth_log2 + 2)) != '0;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port word storage: synchronous write, registered read, no reset.
module data_ram_array
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // The read register only moves on a read, so it holds the last word read.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// Responder for MEM-stage word accesses: capture in IDLE, count wait states,
// then complete in a one-cycle DONE with a ready pulse.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_ce_i,
    input  logic                  ram_w_request_i,
    input  logic [ADDR_WIDTH-1:0] ram_addr_i,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  data_ready_o,
    output logic                  ram_err_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    rsp_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  rd_valid_q, rd_valid_d;

    logic                  range_err;
    logic                  complete;
    logic                  arr_we;
    logic                  arr_re;
    logic [DATA_WIDTH-1:0] arr_rdata;

    assign range_err = addr_out_of_range(addr_q, DEPTH_LOG2);
    assign complete  = (state_q == RSP_WAIT) && (cnt_q == 4'd0);
    // A reset on the completing edge must cancel the array access too.
    assign arr_we    = complete && (we_q == WRITE_ENABLE) && !range_err && !rst_i;
    assign arr_re    = complete && (we_q != WRITE_ENABLE) && !range_err && !rst_i;

    data_ram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk_i  (clk_i),
        .we_i   (arr_we),
        .re_i   (arr_re),
        .addr_i (addr_q[DEPTH_LOG2+1:2]),
        .wdata_i(wdata_q),
        .rdata_o(arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ready_d    = ready_q;
        err_d      = err_q;
        rd_valid_d = rd_valid_q;
        case (state_q)
            RSP_IDLE: begin
                if (ram_ce_i == CHIP_ENABLE) begin
                    addr_d  = ram_addr_i;
                    we_d    = ram_w_request_i;
                    wdata_d = ram_data_i;
                    cnt_d   = WAIT_INIT;
                    state_d = RSP_WAIT;
                end
            end
            RSP_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RSP_DONE;
                    ready_d = READY_ENABLE;
                    err_d   = range_err;
                    if (we_q != WRITE_ENABLE) begin
                        rd_valid_d = !range_err;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RSP_DONE: begin
                state_d = RSP_IDLE;
                ready_d = READY_DISABLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RSP_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= ZERO;
            ready_q    <= READY_DISABLE;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Zero until the first in-range read, and after an out-of-range read.
    assign ram_data_o   = rd_valid_q ? arr_rdata : ZERO;
    assign data_ready_o = ready_q;
    assign ram_err_o    = err_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench: the driver pushes expected completions, a negedge monitor checks them.
module tb_data_ram_responder;

    localparam int W  = 2;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we;
    logic [31:0] addr, wdata, rdata;
    logic        ready, err;

    logic        c0_ce, c0_we;
    logic [31:0] c0_addr, c0_wdata, c0_rdata;
    logic        c0_ready, c0_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          exp_cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model_mem [0:(1<<DL)-1];
    logic [31:0] last_rd;

    data_ram_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(W)) dut (
        .clk_i(clk), .rst_i(rst), .ram_ce_i(ce), .ram_w_request_i(we),
        .ram_addr_i(addr), .ram_data_i(wdata), .ram_data_o(rdata),
        .data_ready_o(ready), .ram_err_o(err)
    );

    data_ram_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .ram_ce_i(c0_ce), .ram_w_request_i(c0_we),
        .ram_addr_i(c0_addr), .ram_data_i(c0_wdata), .ram_data_o(c0_rdata),
        .data_ready_o(c0_ready), .ram_err_o(c0_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: word memory, range rule and "data output holds last read".
    task automatic model_push(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int exp_cyc);
        exp_t e;
        logic oor;
        int   idx;
        oor = (a >> (DL + 2)) != 0;
        idx = int'(a[DL+1:2]);
        e.exp_cyc = exp_cyc;
        e.err     = oor;
        if (w) begin
            if (!oor) model_mem[idx] = d;
            e.data = last_rd;
        end else begin
            last_rd = oor ? 32'h0 : model_mem[idx];
            e.data  = last_rd;
        end
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_ready", {31'h0, ready}, 32'h0);
            end else begin
                e = sbq.pop_front();
                check("latency", cyc, e.exp_cyc);
                check("rdata", rdata, e.data);
                check("err", {31'h0, err}, {31'h0, e.err});
                $display("TXN cyc=%0d data=0x%08h err=%0b", cyc, rdata, err);
            end
        end
    end

    // Called at a negedge with the DUT idle (b2b=0) or in its ready cycle (b2b=1).
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit b2b, input bit scr);
        int acc;
        bit seen;
        acc  = b2b ? cyc + 2 : cyc + 1;
        ce   = 1'b1;
        we   = w;
        addr = a;
        wdata = d;
        model_push(w, a, d, acc + W + 1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
            else if (scr && cyc >= acc) begin
                addr  = 32'h20;
                wdata = 32'h12345678;
                we    = 1'b1;
            end
        end
        if (!seen) check("timeout_ready", {31'h0, ready}, 32'h1);
    endtask

    task automatic idle();
        ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic c0_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_data);
        int  n;
        bit  seen;
        n = cyc;
        c0_ce = 1'b1; c0_we = w; c0_addr = a; c0_wdata = d;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (c0_ready) seen = 1'b1;
        end
        check("w0_latency", cyc, n + 2);
        check("w0_rdata", c0_rdata, exp_data);
        check("w0_err", {31'h0, c0_err}, 32'h0);
        $display("TXN w0 cyc=%0d data=0x%08h err=%0b", cyc, c0_rdata, c0_err);
        c0_ce = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit          b2b_next;
        logic [31:0] a;
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        c0_ce = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
        last_rd = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_w0_ready", {31'h0, c0_ready}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            issue(1'b1, i * 4, $urandom, 1'b0, 1'b0);
            idle();
        end

        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0); idle();
        issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);        idle();
        issue(1'b0, 32'h13, 32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h24, 32'h11112222, 1'b1, 1'b0);
        issue(1'b0, 32'h24, 32'h0, 1'b1, 1'b0);        idle();

        issue(1'b1, 32'h30, 32'hCAFE0001, 1'b0, 1'b1); idle();
        issue(1'b0, 32'h20, 32'h0, 1'b0, 1'b0);        idle();
        issue(1'b0, 32'h30, 32'h0, 1'b0, 1'b0);        idle();

        issue(1'b0, 32'h1000, 32'h0, 1'b0, 1'b0);        idle();
        issue(1'b1, 32'h1000, 32'hBAD0BAD0, 1'b0, 1'b0); idle();
        issue(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);           idle();

        // Abort a write with a one-cycle reset while it waits.
        ce = 1'b1; we = 1'b1; addr = 32'h4; wdata = 32'hA5A5A5A5;
        @(negedge clk);
        rst = 1'b1; ce = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_ready", {31'h0, ready}, 32'h0);
        end
        check("abort_rdata", rdata, 32'h0);
        check("abort_err", {31'h0, err}, 32'h0);
        issue(1'b0, 32'h4, 32'h0, 1'b0, 1'b0); idle();

        b2b_next = 1'b0;
        for (int k = 0; k < 60; k++) begin
            a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 7) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
            issue(1'($urandom_range(0, 1)), a, $urandom, b2b_next, 1'b0);
            b2b_next = 1'($urandom_range(0, 1));
            if (!b2b_next) idle();
        end
        idle();

        c0_req(1'b1, 32'h8, 32'h00000055, 32'h0);
        c0_req(1'b0, 32'h8, 32'h0, 32'h00000055);

        repeat (4) @(negedge clk);
        check("sb_empty", sbq.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
